// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the memory port arbiter, the two pipeline requesters and the
// unified memory.
interface mem_port_arbiter_if;
  logic if_req;
  logic d_req;
  logic d_we;
  logic mem_ready;
  logic mem_rvalid;
  logic addr_sel;
  logic mem_req;
  logic mem_we;
  logic if_done;
  logic d_done;
  logic if_stall;
  logic d_stall;
  logic err;

  // Pipeline + memory side.
  modport master (
    output if_req, d_req, d_we, mem_ready, mem_rvalid,
    input  addr_sel, mem_req, mem_we, if_done, d_done, if_stall, d_stall, err
  );

  // Arbiter side.
  modport slave (
    input  if_req, d_req, d_we, mem_ready, mem_rvalid,
    output addr_sel, mem_req, mem_we, if_done, d_done, if_stall, d_stall, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and load/store,
// one transaction at a time, with a fetch starvation limit and a response timeout.
module mem_port_arbiter #(
  parameter int unsigned StarveMax = 4,
  parameter int unsigned Timeout   = 16
) (
  input logic               clk_i,
  input logic               rst_ni,
  mem_port_arbiter_if.slave arb_io
);

  localparam int unsigned StreakW = $clog2(StarveMax + 1);
  localparam int unsigned TimerW  = $clog2(Timeout);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;  // 0 = fetch, 1 = load/store
  logic               we_q, we_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               err_q, err_d;

  logic grant_d;
  logic mem_req, mem_we, if_done, d_done;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    streak_d = streak_q;
    timer_d  = timer_q;
    err_d    = err_q;
    grant_d  = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    if_done  = 1'b0;
    d_done   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_io.if_req | arb_io.d_req) begin
          // Fetch wins a contended grant only once the data streak hits the limit.
          grant_d = arb_io.d_req & ~(arb_io.if_req & (streak_q == StreakW'(StarveMax)));
          owner_d = grant_d;
          we_d    = arb_io.d_we & grant_d;
          if (!grant_d) begin
            streak_d = '0;
          end else if (arb_io.if_req && streak_q != StreakW'(StarveMax)) begin
            streak_d = streak_q + StreakW'(1);
          end
          state_d = StReq;
        end
      end
      StReq: begin
        mem_req = 1'b1;
        mem_we  = we_q;
        if (arb_io.mem_ready) begin
          timer_d = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        timer_d = timer_q + TimerW'(1);
        if (arb_io.mem_rvalid) begin
          if_done = ~owner_q;
          d_done  = owner_q;
          state_d = StIdle;
        end else if (timer_q == TimerW'(Timeout - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      streak_q <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      streak_q <= streak_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

  assign arb_io.addr_sel = owner_q;
  assign arb_io.mem_req  = mem_req;
  assign arb_io.mem_we   = mem_we;
  assign arb_io.if_done  = if_done;
  assign arb_io.d_done   = d_done;
  assign arb_io.if_stall = arb_io.if_req & ~if_done;
  assign arb_io.d_stall  = arb_io.d_req & ~d_done;
  assign arb_io.err      = err_q;

endmodule
